// File: rtl/plab4_net_router_output_ctrl_pkg.sv
// Shared port indices and one-hot helpers for the ring router output controls.
package plab4_net_router_output_ctrl_pkg;

  typedef enum logic [1:0] {
    PREV = 2'd0,
    TERM = 2'd1,
    NEXT = 2'd2
  } port_idx_e;

  // Route-compute codes are the output port indices themselves.
  localparam logic [1:0] ROUTE_PREV = PREV;
  localparam logic [1:0] ROUTE_TERM = TERM;
  localparam logic [1:0] ROUTE_NEXT = NEXT;

  function automatic logic [2:0] rotl3(input logic [2:0] v);
    return {v[1:0], v[2]};
  endfunction

  function automatic logic [1:0] onehot3_idx(input logic [2:0] v);
    if (v[2])      return NEXT;
    else if (v[1]) return TERM;
    else           return PREV;
  endfunction

endpackage

// File: rtl/plab4_net_router_output_ctrl_arb.sv
// Three-way round-robin arbiter: combinational search from the priority
// pointer; the pointer advances past the winner only when a grant is issued.
module plab4_net_rr_arbiter_3
  import plab4_net_router_output_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] reqs,
  output logic [2:0] grants,
  output logic [1:0] sel
);

  logic [2:0] prio_q;
  logic [2:0] prio_d;
  logic [2:0] win_oh;

  always_comb begin
    win_oh = '0;
    case (prio_q)
      3'b010: begin
        if      (reqs[1]) win_oh = 3'b010;
        else if (reqs[2]) win_oh = 3'b100;
        else if (reqs[0]) win_oh = 3'b001;
      end
      3'b100: begin
        if      (reqs[2]) win_oh = 3'b100;
        else if (reqs[0]) win_oh = 3'b001;
        else if (reqs[1]) win_oh = 3'b010;
      end
      default: begin
        if      (reqs[0]) win_oh = 3'b001;
        else if (reqs[1]) win_oh = 3'b010;
        else if (reqs[2]) win_oh = 3'b100;
      end
    endcase
  end

  always_comb begin
    grants = en ? win_oh : '0;
    sel    = onehot3_idx(grants);
    prio_d = (|grants) ? rotl3(grants) : prio_q;
  end

  always_ff @(posedge clk) begin
    if (reset) prio_q <= 3'b001;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// Output-port control for the ring router: round-robin grant to the three
// input controllers, gated by downstream readiness and link credits.
module plab4_net_router_output_ctrl
  import plab4_net_router_output_ctrl_pkg::*;
#(
  parameter int p_num_free_nbits = 2,
  parameter int p_max_credits    = 3,
  parameter int p_use_credits    = 1
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        domain_ID,
  input  logic [2:0]                  reqs,
  output logic [2:0]                  grants,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [1:0]                  xbar_sel,
  input  logic                        credit_return,
  output logic [p_num_free_nbits-1:0] num_free
);

  localparam logic [p_num_free_nbits-1:0] MAX_CNT = p_num_free_nbits'(p_max_credits);
  localparam logic [p_num_free_nbits-1:0] ONE     = p_num_free_nbits'(1);

  logic [p_num_free_nbits-1:0] cnt_q;
  logic [p_num_free_nbits-1:0] cnt_d;
  logic                        credit_ok;
  logic                        can_send;
  logic                        fire;
  logic                        unused_domain;

  // The domain label is carried for the security checker only.
  assign unused_domain = domain_ID;

  // Reset folds into the enable so no grant leaks out during a reset cycle.
  assign credit_ok = (p_use_credits == 0) || (cnt_q != '0);
  assign can_send  = out_rdy && credit_ok && !reset;

  plab4_net_rr_arbiter_3 u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (can_send),
    .reqs   (reqs),
    .grants (grants),
    .sel    (xbar_sel)
  );

  assign out_val  = |grants;
  assign fire     = out_val;
  assign num_free = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (p_use_credits == 0)
      cnt_d = MAX_CNT;
    else if (fire && !credit_return)
      cnt_d = cnt_q - ONE;
    else if (!fire && credit_return && cnt_q != MAX_CNT)
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= MAX_CNT;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// Bench for the router output control: a credit-gated and a terminal instance
// share stimulus and are both checked every cycle against a behavioural model.
module tb_plab4_net_router_output_ctrl;

  localparam int MAXC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       domain_ID;
  logic [2:0] reqs;
  logic       out_rdy;
  logic       credit_return;

  logic [2:0] grants_c, grants_t;
  logic       out_val_c, out_val_t;
  logic [1:0] xbar_sel_c, xbar_sel_t;
  logic [1:0] num_free_c, num_free_t;

  int total = 0;
  int bad   = 0;
  int ptr [2];
  int cnt [2];

  always #5 clk = ~clk;

  plab4_net_router_output_ctrl #(
    .p_num_free_nbits (2),
    .p_max_credits    (MAXC),
    .p_use_credits    (1)
  ) dut_c (
    .clk           (clk),
    .reset         (reset),
    .domain_ID     (domain_ID),
    .reqs          (reqs),
    .grants        (grants_c),
    .out_val       (out_val_c),
    .out_rdy       (out_rdy),
    .xbar_sel      (xbar_sel_c),
    .credit_return (credit_return),
    .num_free      (num_free_c)
  );

  plab4_net_router_output_ctrl #(
    .p_num_free_nbits (2),
    .p_max_credits    (MAXC),
    .p_use_credits    (0)
  ) dut_t (
    .clk           (clk),
    .reset         (reset),
    .domain_ID     (domain_ID),
    .reqs          (reqs),
    .grants        (grants_t),
    .out_val       (out_val_t),
    .out_rdy       (out_rdy),
    .xbar_sel      (xbar_sel_t),
    .credit_return (credit_return),
    .num_free      (num_free_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic cycle(input logic rst, input logic [2:0] rq, input logic rdy, input logic cr);
    int    win;
    bit    found, can, fire;
    string sfx;
    logic [2:0] g_act;
    logic       v_act;
    logic [1:0] s_act, n_act;
    reset = rst; reqs = rq; out_rdy = rdy; credit_return = cr;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      found = 0;
      win   = 0;
      for (int k = 0; k < 3; k++) begin
        if (!found && rq[(ptr[d] + k) % 3]) begin
          found = 1;
          win   = (ptr[d] + k) % 3;
        end
      end
      can  = !rst && rdy && (d == 1 || cnt[d] > 0);
      fire = can && found;
      sfx  = (d == 0) ? "_cred" : "_term";
      if (d == 0) begin g_act = grants_c; v_act = out_val_c; s_act = xbar_sel_c; n_act = num_free_c; end
      else        begin g_act = grants_t; v_act = out_val_t; s_act = xbar_sel_t; n_act = num_free_t; end
      check({"grants", sfx},   32'(g_act), fire ? 32'(1 << win) : 32'd0);
      check({"out_val", sfx},  32'(v_act), 32'(fire));
      check({"xbar_sel", sfx}, 32'(s_act), fire ? 32'(win) : 32'd0);
      check({"num_free", sfx}, 32'(n_act), 32'(cnt[d]));
      if (rst) begin
        ptr[d] = 0;
        cnt[d] = MAXC;
      end else begin
        if (fire) ptr[d] = (win + 1) % 3;
        if (d == 0) begin
          if (fire && !cr) cnt[d]--;
          else if (!fire && cr) begin
            if (cnt[d] == MAXC) $display("note: illegal credit_return at full count, %0t", $time);
            else cnt[d]++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; domain_ID = 1'b0; reqs = '0; out_rdy = 1'b1; credit_return = 1'b0;
    ptr = '{0, 0};
    cnt = '{MAXC, MAXC};
    @(posedge clk);
    #1;

    cycle(1, 3'b000, 1, 0);
    cycle(1, 3'b000, 1, 0);
    repeat (2) cycle(0, 3'b000, 1, 0);

    // contention rotation with credits returned from the third cycle on
    for (int i = 0; i < 6; i++) cycle(0, 3'b111, 1, i >= 2);

    // credit exhaustion and recovery
    cycle(1, 3'b000, 1, 0);
    repeat (4) cycle(0, 3'b010, 1, 0);
    cycle(0, 3'b010, 1, 1);
    cycle(0, 3'b010, 1, 0);
    cycle(0, 3'b000, 1, 0);

    // backpressure does not consume priority or credits
    cycle(1, 3'b000, 1, 0);
    repeat (4) cycle(0, 3'b100, 0, 0);
    cycle(0, 3'b100, 1, 0);
    cycle(0, 3'b111, 1, 0);

    // simultaneous fire and credit, then an illegal credit at full count
    cycle(1, 3'b000, 1, 0);
    cycle(0, 3'b001, 1, 0);
    cycle(0, 3'b010, 1, 1);
    cycle(0, 3'b000, 1, 0);
    cycle(0, 3'b000, 1, 1);
    cycle(0, 3'b000, 1, 1);
    cycle(0, 3'b000, 1, 0);

    // steady single requester with a reset in the middle
    cycle(1, 3'b000, 1, 0);
    for (int i = 0; i < 10; i++) cycle(i == 5, 3'b001, 1, 0);

    // randomized traffic; credits only returned when the link has room
    for (int i = 0; i < 400; i++) begin
      logic       r_rst, r_rdy, r_cr;
      logic [2:0] r_rq;
      r_rst = ($urandom_range(0, 49) == 0);
      r_rq  = 3'($urandom_range(0, 7));
      r_rdy = ($urandom_range(0, 4) != 0);
      r_cr  = (cnt[0] < MAXC) && ($urandom_range(0, 2) == 0);
      cycle(r_rst, r_rq, r_rdy, r_cr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
